// File: rtl/polygon_query_scheduler_if.sv
// Query/result handshake bundle between the collision requester and polygon_query_scheduler.
interface polygon_query_scheduler_if #(
  parameter int WORLD_BITS   = 32,
  parameter int NUM_POLYGONS = 8
);
  localparam int IDX_W = (NUM_POLYGONS > 1) ? $clog2(NUM_POLYGONS) : 1;

  logic                         query_valid_in;
  logic                         query_ready_out;
  logic signed [WORLD_BITS-1:0] query_x_in;
  logic signed [WORLD_BITS-1:0] query_y_in;
  logic                         result_valid_out;
  logic                         result_ready_in;
  logic [NUM_POLYGONS-1:0]      hit_mask_out;
  logic                         any_hit_out;
  logic [IDX_W-1:0]             first_hit_out;

  modport master (
    output query_valid_in, query_x_in, query_y_in, result_ready_in,
    input  query_ready_out, result_valid_out, hit_mask_out, any_hit_out, first_hit_out
  );

  modport slave (
    input  query_valid_in, query_x_in, query_y_in, result_ready_in,
    output query_ready_out, result_valid_out, hit_mask_out, any_hit_out, first_hit_out
  );
endinterface

// File: rtl/polygon_query_scheduler.sv
// Walks one query point across every polygon of the table, holding each selection DP_LATENCY cycles.
// Optional macro POLY_QUERY_EARLY_EXIT_EN: finish on the first sampled hit.
module polygon_query_scheduler #(
  parameter int WORLD_BITS       = 32,
  parameter int NUM_POLYGONS     = 8,
  parameter int MAX_NUM_VERTICES = 32,
  parameter int DP_LATENCY       = 6,
  localparam int IDX_W  = (NUM_POLYGONS > 1) ? $clog2(NUM_POLYGONS) : 1,
  localparam int VCNT_W = $clog2(MAX_NUM_VERTICES + 1),
  localparam int CNT_W  = $clog2(DP_LATENCY)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  polygon_query_scheduler_if.slave     q,
  output logic [IDX_W-1:0]             poly_idx_out,
  output logic signed [WORLD_BITS-1:0] dp_x_out,
  output logic signed [WORLD_BITS-1:0] dp_y_out,
  input  logic [VCNT_W-1:0]            num_points_in,
  input  logic                         dp_hit_in
);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [NUM_POLYGONS-1:0] mask;
  logic [NUM_POLYGONS-1:0] mask_nxt;
  logic [IDX_W-1:0]        first_hit, first_nxt;
  logic                    any_hit, result_valid, query_ready;
  logic                    degen, sample, last, early;

  // Vertex count is only trustworthy one cycle after the selection moves, hence cnt==1.
  assign degen  = (cnt == CNT_W'(1)) && (num_points_in < VCNT_W'(3));
  assign sample = (cnt == CNT_W'(DP_LATENCY - 1)) && !degen;
  assign last   = (poly_idx_out == IDX_W'(NUM_POLYGONS - 1));
`ifdef POLY_QUERY_EARLY_EXIT_EN
  assign early  = sample && dp_hit_in;
`else
  assign early  = 1'b0;
`endif

  always_comb begin
    mask_nxt = mask;
    if (state == EVAL && sample) mask_nxt[poly_idx_out] = dp_hit_in;
    first_nxt = '0;
    for (int i = NUM_POLYGONS - 1; i >= 0; i--)
      if (mask_nxt[i]) first_nxt = IDX_W'(i);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= IDLE;
      cnt          <= '0;
      mask         <= '0;
      first_hit    <= '0;
      any_hit      <= 1'b0;
      result_valid <= 1'b0;
      query_ready  <= 1'b1;
      poly_idx_out <= '0;
      dp_x_out     <= '0;
      dp_y_out     <= '0;
    end else begin
      case (state)
        IDLE: if (q.query_valid_in) begin
          dp_x_out     <= q.query_x_in;
          dp_y_out     <= q.query_y_in;
          poly_idx_out <= '0;
          mask         <= '0;
          cnt          <= '0;
          query_ready  <= 1'b0;
          state        <= EVAL;
        end
        EVAL: begin
          mask <= mask_nxt;
          if (degen || sample) begin
            if (last || early) begin
              state        <= DONE;
              result_valid <= 1'b1;
              any_hit      <= |mask_nxt;
              first_hit    <= first_nxt;
            end else begin
              poly_idx_out <= poly_idx_out + IDX_W'(1);
              cnt          <= '0;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: if (q.result_ready_in) begin
          result_valid <= 1'b0;
          query_ready  <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign q.query_ready_out  = query_ready;
  assign q.result_valid_out = result_valid;
  assign q.hit_mask_out     = mask;
  assign q.any_hit_out      = any_hit;
  assign q.first_hit_out    = first_hit;

endmodule

// File: tb/tb_polygon_query_scheduler.sv
// Scoreboard bench: rectangle polygon table + datapath emulation, reference model predicts mask/latency.
module tb_polygon_query_scheduler;
  localparam int WB = 32, N = 4, L = 6, MV = 32, IW = 2, VW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  polygon_query_scheduler_if #(.WORLD_BITS(WB), .NUM_POLYGONS(N)) qif();
  logic [IW-1:0]        poly_idx;
  logic signed [WB-1:0] dp_x, dp_y;
  logic [VW-1:0]        num_points;
  logic                 dp_hit;

  polygon_query_scheduler #(.WORLD_BITS(WB), .NUM_POLYGONS(N), .MAX_NUM_VERTICES(MV), .DP_LATENCY(L)) dut (
    .clk_in(clk), .rst_in(rst), .q(qif), .poly_idx_out(poly_idx),
    .dp_x_out(dp_x), .dp_y_out(dp_y), .num_points_in(num_points), .dp_hit_in(dp_hit)
  );

  int rx0[N], rx1[N], ry0[N], ry1[N], npts[N];
  int checks = 0, errors = 0, cyc = 0, stall = 0;

  typedef struct {
    logic [N-1:0]  mask;
    logic          any;
    logic [IW-1:0] first;
    int            lat, acc, x, y;
  } exp_t;
  exp_t exp_q[$];

  function automatic bit in_rect(int i, int x, int y);
    return x >= rx0[i] && x <= rx1[i] && y >= ry0[i] && y <= ry1[i];
  endfunction

  // Reference: walk the table in order; degenerate polygons cost 2 cycles and never hit.
  function automatic exp_t model(int x, int y);
    exp_t e;
    bit stop = 0;
    e.mask = '0; e.lat = 1; e.first = '0; e.x = x; e.y = y; e.acc = 0;
    for (int i = 0; i < N; i++) begin
      if (!stop) begin
        if (npts[i] < 3) e.lat += 2;
        else begin
          e.lat += L;
          if (in_rect(i, x, y)) begin
            e.mask[i] = 1'b1;
`ifdef POLY_QUERY_EARLY_EXIT_EN
            stop = 1;
`endif
          end
        end
      end
    end
    e.any = |e.mask;
    for (int i = N - 1; i >= 0; i--) if (e.mask[i]) e.first = IW'(i);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Polygon table + datapath: vertex count valid one cycle after selection changes,
  // hit only valid once selection has been stable L-1 cycles; otherwise garbage.
  logic [2*WB+IW-1:0] hist[L-1];
  wire  [2*WB+IW-1:0] cur = {dp_x, dp_y, poly_idx};
  always @(posedge clk) begin
    cyc <= cyc + 1;
    hist[0] <= cur;
    for (int k = 1; k < L - 1; k++) hist[k] <= hist[k-1];
  end
  always @(negedge clk) begin
    bit settled;
    settled = 1;
    for (int k = 0; k < L - 1; k++) if (hist[k] !== cur) settled = 0;
    num_points = (hist[0] === cur) ? VW'(npts[poly_idx]) : VW'($urandom);
    dp_hit     = settled ? in_rect(int'(poly_idx), dp_x, dp_y) : 1'($urandom);
  end

  // Monitor: latency, hold stability, busy flag, result contents, ready after handshake.
  bit seen = 0, rdy_next = 0;
  logic [N+IW:0] held;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      seen = 0; rdy_next = 0; qif.result_ready_in = 1'b0;
    end else begin
      if (rdy_next) begin
        chk("ready_after_handshake", qif.query_ready_out, 1);
        chk("valid_drops", qif.result_valid_out, 0);
        rdy_next = 0;
      end
      if (!qif.query_ready_out && exp_q.size() > 0)
        chk("dp_xy_hold", {dp_x, dp_y}, {exp_q[0].x, exp_q[0].y});
      if (qif.result_valid_out) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
          qif.result_ready_in = 1'b1;
        end else begin
          e = exp_q[0];
          if (!seen) begin
            seen = 1;
            chk("latency", cyc - e.acc, e.lat);
            held = {qif.hit_mask_out, qif.any_hit_out, qif.first_hit_out};
          end else
            chk("held_stable", {qif.hit_mask_out, qif.any_hit_out, qif.first_hit_out}, held);
          chk("busy_in_done", qif.query_ready_out, 0);
          if (stall > 0) begin stall--; qif.result_ready_in = 1'b0; end
          else qif.result_ready_in = ($urandom % 4) != 0;
          if (qif.result_ready_in) begin
            void'(exp_q.pop_front());
            chk("hit_mask", qif.hit_mask_out, e.mask);
            chk("any_hit", qif.any_hit_out, e.any);
            chk("first_hit", qif.first_hit_out, e.first);
            seen = 0; rdy_next = 1;
          end
        end
      end else qif.result_ready_in = 1'($urandom);
    end
  end

  task automatic do_query(input int x, input int y);
    exp_t e;
    int n = 0;
    while (!qif.query_ready_out && n < 500) begin @(negedge clk); n++; end
    if (n == 500) chk("query_ready_timeout", 0, 1);
    qif.query_valid_in = 1'b1; qif.query_x_in = x; qif.query_y_in = y;
    e = model(x, y); e.acc = cyc;
    exp_q.push_back(e);
    @(negedge clk);
    qif.query_valid_in = 1'b0; qif.query_x_in = $urandom; qif.query_y_in = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || !qif.query_ready_out) && n < 1000) begin @(negedge clk); n++; end
    if (n == 1000) chk("idle_timeout", 0, 1);
  endtask

  task automatic set_rect(input int i, input int x0, input int x1, input int y0, input int y1, input int np);
    rx0[i] = x0; rx1[i] = x1; ry0[i] = y0; ry1[i] = y1; npts[i] = np;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_query_ready"}, qif.query_ready_out, 1);
    chk({tag, "_result_valid"}, qif.result_valid_out, 0);
    chk({tag, "_poly_idx"}, poly_idx, 0);
    chk({tag, "_hit_mask"}, qif.hit_mask_out, 0);
    chk({tag, "_any_first"}, {qif.any_hit_out, qif.first_hit_out}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    qif.query_valid_in = 1'b0; qif.query_x_in = 0; qif.query_y_in = 0;
    for (int i = 0; i < N; i++) set_rect(i, 0, 100, 0, 100, 4);
    repeat (3) @(negedge clk);
    chk_reset_state("reset");
    chk("reset_dp_xy", {dp_x, dp_y}, 0);
    rst = 1'b0;
    @(negedge clk);

    // No hits
    do_query(1000, 1000);
    wait_idle();

    // Overlapping hits at 1 and 3
    set_rect(0, 200, 300, 0, 100, 4);
    set_rect(1, 0, 100, 0, 100, 4);
    set_rect(2, -300, -200, 0, 100, 5);
    set_rect(3, -200, 200, -200, 200, 4);
    do_query(50, 50);
    wait_idle();

    // Degenerate polygon 2 that would otherwise contain the point
    set_rect(2, 0, 100, 0, 100, 2);
    do_query(50, 50);
    wait_idle();

    // Backpressure with an ignored query pulse in DONE
    stall = 10;
    do_query(50, 50);
    n = 0;
    while (!qif.result_valid_out && n < 200) begin @(negedge clk); n++; end
    if (n == 200) chk("done_timeout", 0, 1);
    @(negedge clk);
    qif.query_valid_in = 1'b1; qif.query_x_in = 7; qif.query_y_in = 7;
    @(negedge clk);
    qif.query_valid_in = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("no_spurious_accept", qif.query_ready_out, 1);

    // Reset mid-EVAL
    set_rect(2, 0, 100, 0, 100, 4);
    do_query(50, 50);
    n = 0;
    while (poly_idx != 2 && n < 200) begin @(negedge clk); n++; end
    if (n == 200) chk("poly2_timeout", 0, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_state("mid_eval_reset");
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);

    // Randomized tables and points
    for (int t = 0; t < 30; t++) begin
      wait_idle();
      for (int i = 0; i < N; i++) begin
        int a = $urandom_range(0, 60) - 30, b = $urandom_range(0, 60) - 30;
        set_rect(i, a - 40, a + 40, b - 40, b + 40,
                 ($urandom % 4 == 0) ? $urandom_range(0, 2) : $urandom_range(3, 32));
      end
      do_query($urandom_range(0, 100) - 50, $urandom_range(0, 100) - 50);
    end
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
